// File: rtl/sha_stream_frontend.sv
// sha_stream_frontend: streams a message into shared memory, starts the SHA core,
// then reads the eight hash words back out as a valid/ready stream.
module sha_stream_frontend #(
  parameter int NUM_OF_WORDS = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] input_addr,
  input  logic [15:0] hash_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        core_start,
  input  logic        core_done,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam int CW = ($clog2(NUM_OF_WORDS + 1) < 4) ? 4 : $clog2(NUM_OF_WORDS + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(NUM_OF_WORDS - 1);
  localparam logic [CW-1:0] LAST_HASH = CW'(7);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_ACK  = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] RD_ADDR   = 3'd5;
  localparam logic [2:0] RD_CAP    = 3'd6;
  localparam logic [2:0] SEND      = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   in_base_q, in_base_d, hash_base_q, hash_base_d;
  logic          mem_we_q, mem_we_d, mem_sel_q, mem_sel_d, core_start_q, core_start_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d, out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;

  assign in_ready   = (state_q == IDLE) || (state_q == LOAD);
  assign busy       = state_q != IDLE;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_sel    = mem_sel_q;
  assign core_start = core_start_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_base_d    = in_base_q;
    hash_base_d  = hash_base_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_sel_d    = mem_sel_q;
    core_start_d = 1'b0;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    case (state_q)
      IDLE: if (in_valid) begin
        in_base_d   = input_addr;
        hash_base_d = hash_addr;
        mem_we_d    = 1'b1;
        mem_addr_d  = input_addr;
        mem_wdata_d = in_data;
        cnt_d       = CW'(1);
        state_d     = (NUM_OF_WORDS == 1) ? START : LOAD;
      end
      LOAD: if (in_valid) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = in_base_q + 16'(cnt_q);
        mem_wdata_d = in_data;
        cnt_d       = cnt_q + 1'b1;
        state_d     = (cnt_q == LAST_WORD) ? START : LOAD;
      end
      START: begin
        core_start_d = 1'b1;
        mem_sel_d    = 1'b1;
        state_d      = WAIT_ACK;
      end
      WAIT_ACK: state_d = core_done ? WAIT_ACK : WAIT_DONE;
      // The read address is presented on entry to RD_ADDR so the synchronous
      // memory returns data in RD_CAP.
      WAIT_DONE: if (core_done) begin
        mem_sel_d  = 1'b0;
        cnt_d      = '0;
        mem_addr_d = hash_base_q;
        state_d    = RD_ADDR;
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
        out_last_d  = cnt_q == LAST_HASH;
        state_d     = SEND;
      end
      SEND: if (out_ready) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        cnt_d       = (cnt_q == LAST_HASH) ? cnt_q : cnt_q + 1'b1;
        mem_addr_d  = (cnt_q == LAST_HASH) ? mem_addr_q : hash_base_q + 16'(cnt_q) + 16'd1;
        state_d     = (cnt_q == LAST_HASH) ? IDLE : RD_ADDR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      in_base_q    <= '0;
      hash_base_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_sel_q    <= 1'b0;
      core_start_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_base_q    <= in_base_d;
      hash_base_q  <= hash_base_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_sel_q    <= mem_sel_d;
      core_start_q <= core_start_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end
endmodule

// File: tb/tb_sha_stream_frontend.sv
// tb_sha_stream_frontend: directed checks of load, core handshake, hash readback,
// backpressure, reset and address wrap.
module tb_sha_stream_frontend;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] input_addr, hash_addr, mem_addr;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [31:0] in_data, out_data, mem_wdata, mem_rdata;
  logic        core_start, core_done, mem_sel, mem_we, busy;
  logic [15:0] w_input_addr, w_mem_addr;
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_last, w_core_start, w_mem_sel, w_mem_we, w_busy;
  logic [31:0] w_in_data, w_out_data, w_mem_wdata;
  int          checks = 0, fails = 0;
  int          core_cnt;

  always #5 clk = ~clk;

  sha_stream_frontend #(.NUM_OF_WORDS(40)) dut (
    .clk(clk), .rst_n(rst_n), .input_addr(input_addr), .hash_addr(hash_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_start(core_start), .core_done(core_done), .mem_sel(mem_sel), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  sha_stream_frontend #(.NUM_OF_WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .input_addr(w_input_addr), .hash_addr(16'h0000),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data), .out_last(w_out_last),
    .core_start(w_core_start), .core_done(1'b1), .mem_sel(w_mem_sel), .mem_we(w_mem_we),
    .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_rdata(32'h0), .busy(w_busy));

  // Core model: done drops the edge after start and returns after 100 cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      core_done <= 1'b1;
      core_cnt  <= 0;
    end else if (core_start) begin
      core_done <= 1'b0;
      core_cnt  <= 100;
    end else if (!core_done) begin
      if (core_cnt == 1) core_done <= 1'b1;
      core_cnt <= core_cnt - 1;
    end
  end

  // Synchronous memory holding hash words 0xA0..0xA7 at 0x0100.
  always @(posedge clk)
    mem_rdata <= (mem_addr[15:3] == 13'h0020) ? 32'hA0 + 32'(mem_addr[2:0]) : 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] base, input logic [15:0] hbase, input int gap_at);
    input_addr = base;
    hash_addr  = hbase;
    for (int i = 0; i < 40; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (3) begin
          step();
          chk("gap_we", mem_we, 1'b0);
        end
      end
      in_valid = 1'b1;
      in_data  = 32'(i);
      step();
      chk("wr_we", mem_we, 1'b1);
      chk("wr_addr", mem_addr, base + 16'(i));
      chk("wr_data", mem_wdata, 32'(i));
      if (i == 0) begin
        input_addr = 16'hDEAD;
        hash_addr  = 16'hBEEF;
      end
    end
    in_valid = 1'b0;
    chk("start_in_ready", in_ready, 1'b0);
    chk("start_early", core_start, 1'b0);
    step();
    chk("core_start", core_start, 1'b1);
    chk("start_mem_sel", mem_sel, 1'b1);
    chk("start_we", mem_we, 1'b0);
    step();
    chk("core_start_once", core_start, 1'b0);
  endtask

  task automatic drain();
    int n = 0, words = 0;
    out_ready = 1'b1;
    while (busy && n < 400) begin
      step();
      n++;
      if (out_valid) words++;
    end
    chk("drain_busy", busy, 1'b0);
    chk("drain_words", 32'(words), 32'd8);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n, viol, w;
    logic [15:0] exp_wrap [4];
    exp_wrap = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; input_addr = '0; hash_addr = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_input_addr = '0;
    repeat (2) step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_start", core_start, 1'b0);
    chk("rst_sel", mem_sel, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    step();
    load(16'h0000, 16'h0100, -1);
    n = 0; viol = 0;
    while (mem_sel && n < 300) begin
      if (mem_we) viol++;
      n++;
      step();
    end
    chk("mem_sel_span", 32'(n), 32'd101);
    chk("busy_we", 32'(viol), 32'd0);
    chk("rd_first_addr", mem_addr, 16'h0100);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      while (!out_valid && w < 10) begin
        step();
        w++;
      end
      chk("rd_latency", 32'(w), 32'd2);
      chk("rd_data", out_data, 32'hA0 + 32'(k));
      chk("rd_last", out_last, k == 7);
      chk("rd_we", mem_we, 1'b0);
      if (k == 3) begin
        out_ready = 1'b0;
        repeat (5) begin
          step();
          chk("bp_valid", out_valid, 1'b1);
          chk("bp_data", out_data, 32'hA3);
          chk("bp_addr", mem_addr, 16'h0103);
        end
        out_ready = 1'b1;
      end
      step();
      chk("rd_valid_clr", out_valid, 1'b0);
    end
    chk("end_busy", busy, 1'b0);
    chk("end_in_ready", in_ready, 1'b1);
    load(16'h0000, 16'h0100, 6);
    drain();
    input_addr = 16'h0300;
    hash_addr  = 16'h0100;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h55 + 32'(i);
      step();
    end
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 1'b0);
    chk("mid_rst_addr", mem_addr, 16'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_sel", mem_sel, 1'b0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    load(16'h0400, 16'h0100, -1);
    drain();
    w_input_addr = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      w_in_valid = 1'b1;
      w_in_data  = 32'h70 + 32'(i);
      step();
      chk("wrap_we", w_mem_we, 1'b1);
      chk("wrap_addr", w_mem_addr, exp_wrap[i]);
    end
    w_in_valid = 1'b0;
    step();
    chk("wrap_start", w_core_start, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sha_stream_frontend.md
# sha_stream_frontend

Streaming front/back end for the simplified SHA-256 core. Accepts a message as a valid/ready stream of 32-bit words, writes it into the shared message memory at `input_addr`, and pulses the core's `start`. After the core reports completion, it reads the 8 hash words back from `hash_addr` and emits them on a valid/ready output stream. It owns the shared memory port except while the core is running; `mem_sel` steers the external memory mux.

## Interface
- `NUM_OF_WORDS`, default 40: message length in 32-bit words; must match the core; range 1..1023.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `input_addr` input 16: base address of the message buffer; sampled on the first accepted input word.
- `hash_addr` input 16: base address of the hash result; sampled on the first accepted input word.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: frontend can accept a word.
- `in_data` input 32: message word, most significant word first.
- `out_valid` output 1: hash word valid.
- `out_ready` input 1: downstream accepts the hash word.
- `out_data` output 32: hash word, H0 first.
- `out_last` output 1: high with H7.
- `core_start` output 1: one-cycle start pulse to the core.
- `core_done` input 1: core done; high while the core is idle.
- `mem_sel` output 1: 0 = frontend drives memory, 1 = core drives memory.
- `mem_we` output 1: memory write enable.
- `mem_addr` output 16: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_rdata` input 32: memory read data, valid one cycle after the address is presented.
- `busy` output 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, RD_ADDR, RD_CAP, SEND.
- **IDLE:** `in_ready`=1. On `in_valid`:
  - latch both base addresses;
  - write word 0;
  - set word counter `cnt`=1;
  - go to LOAD. If `NUM_OF_WORDS`=1, go straight to START instead.
- **LOAD:** `in_ready`=1. Each handshake registers `mem_we`=1, `mem_addr`=input_addr+cnt, `mem_wdata`=in_data, and increments `cnt`.
  - The handshake that writes word `NUM_OF_WORDS`-1 moves to START.
  - Cycles with no handshake register `mem_we`=0.
- **START:**
  - `mem_we`=0, `in_ready`=0, `mem_sel`=1.
  - `core_start`=1 for exactly this cycle.
  - Go to WAIT_ACK.
- **WAIT_ACK:** `mem_sel`=1. Stay until `core_done`=0, then go to WAIT_DONE.
- **WAIT_DONE:** `mem_sel`=1. Stay until `core_done`=1, then set `mem_sel`=0, `cnt`=0, and go to RD_ADDR.
- **RD_ADDR:** drive `mem_addr`=hash_addr+cnt with `mem_we`=0, then go to RD_CAP.
- **RD_CAP:** register `out_data`=mem_rdata, set `out_valid`=1, set `out_last`=(cnt==7), then go to SEND.
- **SEND:** hold `out_data`, `out_valid` and `out_last` until `out_ready`. On the handshake, clear `out_valid`. If `cnt`=7, go to IDLE; otherwise increment `cnt` and go to RD_ADDR.
- **Address arithmetic:** 16-bit, wraps modulo 2^16 (e.g. base 0xFFFF + 1 = 0x0000).
- **Counter:** `cnt` is `$clog2(NUM_OF_WORDS+1)` bits wide, minimum 4.
- **Combinational outputs:** `in_ready` is combinational from state (IDLE or LOAD) only. It never depends on `out_ready`.
- **Registered outputs:** all memory outputs, `core_start`, `out_*` and `mem_sel` are registered.
- **Ignored inputs:**
  - `in_valid` is ignored outside IDLE/LOAD.
  - `core_done` is ignored outside WAIT_ACK/WAIT_DONE.
  - `out_ready` is ignored outside SEND.

## Timing
- **Reset values:** all outputs 0 (`in_ready` 1, since the reset state is IDLE). State IDLE, `cnt`=0.
- **Reset mid-operation:** asynchronous return to IDLE on any state.
  - `core_start` and `mem_we` deassert immediately.
  - A partially written message is abandoned; the next message restarts at word 0.
- **Write latency:** an input handshake at edge t produces `mem_we`/`mem_addr`/`mem_wdata` valid from t+1 to t+2.
- **Back-to-back writes:** with `in_valid` held high, the load takes `NUM_OF_WORDS` cycles.
- **Start:** `core_start` is asserted the cycle after the last write. `mem_sel` rises in the same cycle and stays high until `core_done` returns high.
- **Read latency:** RD_ADDR to `out_valid` is 2 cycles per word. With `out_ready` held high, each hash word takes 3 cycles (24 cycles for all 8).
- **Backpressure:** `out_data` must not change while `out_valid`=1 and `out_ready`=0.
- **Bus ownership:** no memory access from the frontend while `mem_sel`=1. `mem_we`=0 throughout START..WAIT_DONE and during hash readback.
- **Accept-ready:** a new message can be accepted in the cycle after the final `out_last` handshake.

## Test plan
- **Load timing:** reset, then stream 40 words 0x00000000..0x00000027 with `in_valid` held high and base addresses 0x0000/0x0100. Expect writes to addresses 0x0000..0x0027 on consecutive cycles, and `core_start` high for exactly 1 cycle the cycle after the 0x0027 write.
- **Sparse input:** insert a 3-cycle `in_valid` gap after word 5. Expect `mem_we`=0 during the gap, word 6 at 0x0006, and no duplicated or skipped addresses.
- **End-to-end hash:** use a behavioural core model with a memory preloaded with hash words 0xA0..0xA7 at 0x0100, holding `core_done` low for 100 cycles. Expect `mem_sel`=1 for that span, then output words 0xA0..0xA7 in order, `out_last` only with 0xA7, and `busy` falling after that handshake.
- **Output backpressure:** hold `out_ready` low for 5 cycles at word 3. Expect `out_data` and `out_valid` stable throughout and no extra memory reads.
- **Address wrap:** `input_addr`=0xFFFE with `NUM_OF_WORDS`=4. Expect writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Reset mid-load:** assert `rst_n` low after 10 words. Expect all outputs at reset values immediately. Then load a full message and expect its first write at `input_addr`+0.
